// File: rtl/fpu_divsqrt.sv
// Iterative single-precision divide / square-root unit.
// Radix-2 restoring iteration, one quotient/root bit per cycle. The first 25
// iteration cycles produce the bits; any further cycles (ITER > 25) only pad
// the latency. Specials are detected at UNPACK and muxed in at PACK, so every
// operation completes exactly ITER+2 cycles after its issue edge.
module fpu_divsqrt #(
  parameter int ITER = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  opcode,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf,
  output logic        unf,
  output logic        out_valid,
  output logic        busy
);

  // 24 result bits plus one integer bit for quotient normalisation
  localparam int NBITS = 25;
  localparam int CW    = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_ITER, S_PACK} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]        r_x1;
  logic [31:0]        r_x2;
  logic               r_op_sqrt;
  logic [CW-1:0]      r_cnt;
  logic [27:0]        r_rem;
  logic [24:0]        r_q;
  logic [23:0]        r_divisor;
  logic [49:0]        r_rad;
  logic signed [10:0] r_exp;
  logic               r_sign;
  logic               r_special;
  logic [31:0]        r_spec_y;
  logic [31:0]        r_y;
  logic               r_ovf;
  logic               r_unf;
  logic               r_out_valid;

  logic w_issue;
  logic w_unused_opcode;

  // Only bits 3 and 4 select an operation; the rest of the opcode bus belongs to other units
  assign w_unused_opcode = ^{opcode[7:5], opcode[2:0]};
  assign w_issue = (r_state == S_IDLE) && (opcode[3] || opcode[4]);

  // ---------------------------------------------------------------------
  // Operand field split (from latched operands, used during UNPACK)
  // ---------------------------------------------------------------------
  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_a_zero, w_a_inf, w_a_nan;
  logic        w_b_zero, w_b_inf, w_b_nan;
  logic [23:0] w_ma, w_mb;

  assign w_sa = r_x1[31];
  assign w_ea = r_x1[30:23];
  assign w_fa = r_x1[22:0];
  assign w_sb = r_x2[31];
  assign w_eb = r_x2[30:23];
  assign w_fb = r_x2[22:0];

  // Denormals have a zero exponent field and are flushed to signed zero
  assign w_a_zero = (w_ea == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);

  assign w_ma = {1'b1, w_fa};
  assign w_mb = {1'b1, w_fb};

  // Exponents: divide is ea-eb+bias; sqrt halves the unbiased exponent,
  // first making it even (odd case doubles the radicand mantissa instead)
  logic signed [10:0] w_exp_div;
  logic signed [10:0] w_eu;
  logic signed [10:0] w_eu_even;
  logic signed [10:0] w_exp_sqrt;
  logic               w_odd;
  logic [24:0]        w_m25;
  logic [49:0]        w_rad;

  assign w_exp_div  = $signed({3'b000, w_ea}) - $signed({3'b000, w_eb}) + 11'sd127;
  assign w_eu       = $signed({3'b000, w_ea}) - 11'sd127;
  assign w_odd      = ~w_ea[0];
  assign w_eu_even  = w_eu - $signed({10'd0, w_odd});
  assign w_exp_sqrt = (w_eu_even >>> 1) + 11'sd127;
  assign w_m25      = w_odd ? {w_ma, 1'b0} : {1'b0, w_ma};
  // Radicand scaled so its integer square root carries 24 significant bits
  assign w_rad      = {2'b00, w_m25, 23'd0};

  // Special-case detection; results here bypass the iteration entirely
  logic        w_spec;
  logic [31:0] w_spec_y;
  logic        w_qsign;

  assign w_qsign = w_sa ^ w_sb;

  // Classify operands into the fixed special-result table
  always_comb begin
    w_spec   = 1'b0;
    w_spec_y = 32'd0;
    if (r_op_sqrt) begin
      if (w_a_nan) begin
        w_spec   = 1'b1;
        w_spec_y = 32'h7FC00000;
      end else if (w_a_zero) begin
        w_spec   = 1'b1;
        w_spec_y = {w_sa, 31'd0};
      end else if (w_sa) begin
        w_spec   = 1'b1;
        w_spec_y = 32'h7FC00000;
      end else if (w_a_inf) begin
        w_spec   = 1'b1;
        w_spec_y = 32'h7F800000;
      end
    end else begin
      if (w_a_nan || w_b_nan) begin
        w_spec   = 1'b1;
        w_spec_y = 32'h7FC00000;
      end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
        w_spec   = 1'b1;
        w_spec_y = 32'h7FC00000;
      end else if (w_a_inf || w_b_zero) begin
        w_spec   = 1'b1;
        w_spec_y = {w_qsign, 8'hFF, 23'd0};
      end else if (w_a_zero || w_b_inf) begin
        w_spec   = 1'b1;
        w_spec_y = {w_qsign, 31'd0};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------
  logic        w_div_ge;
  logic [27:0] w_div_rem;
  logic [27:0] w_sq_cur;
  logic [27:0] w_sq_trial;
  logic        w_sq_ge;
  logic [27:0] w_sq_rem;

  // Restoring divide: subtract divisor when it fits, then shift remainder up
  assign w_div_ge  = (r_rem >= {4'd0, r_divisor});
  assign w_div_rem = (w_div_ge ? (r_rem - {4'd0, r_divisor}) : r_rem) << 1;

  // Restoring square root: bring down two radicand bits, try root*4+1
  assign w_sq_cur   = {r_rem[25:0], r_rad[49:48]};
  assign w_sq_trial = {1'b0, r_q, 2'b01};
  assign w_sq_ge    = (w_sq_cur >= w_sq_trial);
  assign w_sq_rem   = w_sq_ge ? (w_sq_cur - w_sq_trial) : w_sq_cur;

  // ---------------------------------------------------------------------
  // Pack: normalise, range-check, select special
  // ---------------------------------------------------------------------
  logic signed [10:0] w_pexp;
  logic [22:0]        w_frac;
  logic [31:0]        w_pack_y;
  logic               w_pack_ovf;
  logic               w_pack_unf;

  // Quotient below one drops a place and an exponent; the root is always normalised
  always_comb begin
    w_pexp = r_exp;
    w_frac = r_q[22:0];
    if (!r_op_sqrt && r_q[24]) begin
      w_frac = r_q[23:1];
    end else if (!r_op_sqrt) begin
      w_pexp = r_exp - 11'sd1;
    end
  end

  // Final result mux with overflow/underflow saturation
  always_comb begin
    w_pack_y   = {r_sign, w_pexp[7:0], w_frac};
    w_pack_ovf = 1'b0;
    w_pack_unf = 1'b0;
    if (r_special) begin
      w_pack_y = r_spec_y;
    end else if (w_pexp >= 11'sd255) begin
      w_pack_y   = {r_sign, 8'hFF, 23'd0};
      w_pack_ovf = 1'b1;
    end else if (w_pexp <= 11'sd0) begin
      w_pack_y   = {r_sign, 31'd0};
      w_pack_unf = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: fixed-length walk through UNPACK, ITER cycles, PACK
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_issue) w_state_next = S_UNPACK;
      S_UNPACK: w_state_next = S_ITER;
      S_ITER:   if (r_cnt == CW'(ITER - 1)) w_state_next = S_PACK;
      S_PACK:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands, set up iteration, step, and load the result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x1        <= 32'd0;
      r_x2        <= 32'd0;
      r_op_sqrt   <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= 28'd0;
      r_q         <= 25'd0;
      r_divisor   <= 24'd0;
      r_rad       <= 50'd0;
      r_exp       <= 11'sd0;
      r_sign      <= 1'b0;
      r_special   <= 1'b0;
      r_spec_y    <= 32'd0;
      r_y         <= 32'd0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_x1      <= x1;
            r_x2      <= x2;
            r_op_sqrt <= opcode[4] & ~opcode[3];
          end
        end
        S_UNPACK: begin
          r_cnt     <= '0;
          r_special <= w_spec;
          r_spec_y  <= w_spec_y;
          r_sign    <= r_op_sqrt ? 1'b0 : w_qsign;
          r_exp     <= r_op_sqrt ? w_exp_sqrt : w_exp_div;
          r_divisor <= w_mb;
          r_rem     <= r_op_sqrt ? 28'd0 : {4'd0, w_ma};
          r_rad     <= w_rad;
          r_q       <= 25'd0;
        end
        S_ITER: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt < CW'(NBITS)) begin
            if (r_op_sqrt) begin
              r_rem <= w_sq_rem;
              r_q   <= {r_q[23:0], w_sq_ge};
              r_rad <= r_rad << 2;
            end else begin
              r_rem <= w_div_rem;
              r_q   <= {r_q[23:0], w_div_ge};
            end
          end
        end
        S_PACK: begin
          r_y         <= w_pack_y;
          r_ovf       <= w_pack_ovf;
          r_unf       <= w_pack_unf;
          r_out_valid <= 1'b1;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign y         = r_y;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);

endmodule
